// File: rtl/credit_down_counter.sv
// Credit tracker: gates a go request stream so that at most MAX_CREDITS requests are outstanding.
// Optional macro CREDIT_SVA_EN embeds concurrent assertions on the credit bound and grant/deny behaviour.
module credit_down_counter #(
    parameter int MAX_CREDITS = 3,
    parameter int CW          = $clog2(MAX_CREDITS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          init,
    input  logic          go,
    input  logic          ret,
    output logic          grant,
    output logic          deny,
    output logic [CW-1:0] credits,
    output logic          empty,
    output logic          full,
    output logic          overflow_err,
    output logic [1:0]    state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [CW-1:0] MAX_C = CW'(MAX_CREDITS);
    localparam logic [CW-1:0] ONE_C = CW'(1);
    localparam logic [CW-1:0] ZERO_C = CW'(0);

    state_t        state_r, state_s;
    logic [CW-1:0] credits_r, credits_s;
    logic          grant_r, grant_s;
    logic          deny_r, deny_s;
    logic          overflow_err_r, overflow_err_s;

    // State and registered-output update; reset wins over every other input
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r        <= IDLE;
            credits_r      <= ZERO_C;
            grant_r        <= 1'b0;
            deny_r         <= 1'b0;
            overflow_err_r <= 1'b0;
        end else begin
            state_r        <= state_s;
            credits_r      <= credits_s;
            grant_r        <= grant_s;
            deny_r         <= deny_s;
            overflow_err_r <= overflow_err_s;
        end
    end

    // Next-state and next-credit decode; init always takes priority over go/ret
    always_comb begin
        state_s        = state_r;
        credits_s      = credits_r;
        grant_s        = 1'b0;
        deny_s         = 1'b0;
        overflow_err_s = overflow_err_r;
        case (state_r)
            IDLE: begin
                if (init) begin
                    credits_s      = MAX_C;
                    overflow_err_s = 1'b0;
                    state_s        = RUN;
                end else begin
                    credits_s = credits_r;
                end
            end
            RUN: begin
                if (init) begin
                    credits_s      = MAX_C;
                    overflow_err_s = 1'b0;
                end else if (go && ret) begin
                    // A simultaneous return funds the request, so even an empty or full pool nets to zero
                    grant_s = 1'b1;
                end else if (go) begin
                    if (credits_r != ZERO_C) begin
                        credits_s = credits_r - ONE_C;
                        grant_s   = 1'b1;
                    end else begin
                        deny_s = 1'b1;
                    end
                end else if (ret) begin
                    if (credits_r < MAX_C) begin
                        credits_s = credits_r + ONE_C;
                    end else begin
                        overflow_err_s = 1'b1;
                        state_s        = ERR;
                    end
                end else begin
                    credits_s = credits_r;
                end
            end
            ERR: begin
                if (init) begin
                    credits_s      = MAX_C;
                    overflow_err_s = 1'b0;
                    state_s        = RUN;
                end else if (go) begin
                    deny_s = 1'b1;
                end else begin
                    credits_s = credits_r;
                end
            end
            default: begin
                state_s        = IDLE;
                credits_s      = ZERO_C;
                overflow_err_s = 1'b0;
            end
        endcase
    end

    // Output drive: pulses and count come straight from registers, flags decode the credit register
    always_comb begin
        grant        = grant_r;
        deny         = deny_r;
        credits      = credits_r;
        overflow_err = overflow_err_r;
        state_o      = state_r;
        empty        = (credits_r == ZERO_C);
        full         = (credits_r == MAX_C);
    end

`ifdef CREDIT_SVA_EN
    a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
        credits_r <= MAX_C)
        else $error("a_credit_bound t=%0t credits=%0d sampled=%0d", $time, credits, $sampled(credits));

    a_grant_deny_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(grant_r && deny_r))
        else $error("a_grant_deny_excl t=%0t credits=%0d sampled=%0d", $time, credits, $sampled(credits));

    a_deny_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
        (state_r == RUN) && go && !ret && !init && (credits_r == ZERO_C) |=> deny_r)
        else $error("a_deny_when_empty t=%0t credits=%0d sampled=%0d", $time, credits, $sampled(credits));

    a_overflow_cause: assert property (@(posedge clk) disable iff (!reset_n)
        $rose(overflow_err_r) |-> $past(ret && full))
        else $error("a_overflow_cause t=%0t credits=%0d sampled=%0d", $time, credits, $sampled(credits));
`else
`endif

endmodule

// File: tb/tb_credit_down_counter.sv
// Self-checking bench for credit_down_counter: directed scenarios plus random traffic against a reference model.
module tb_credit_down_counter;

    localparam int MAX = 3;
    localparam int CW  = $clog2(MAX + 1);
    localparam int VW  = 7 + CW;

    logic          clk = 1'b0;
    logic          reset_n, init, go, ret;
    logic          grant, deny, empty, full, overflow_err;
    logic [CW-1:0] credits;
    logic [1:0]    state_o;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=idle 1=run 2=err, plain integer credit pool
    int m_mode, m_cred, m_grant, m_deny, m_ovf;

    credit_down_counter #(.MAX_CREDITS(MAX)) dut (
        .clk(clk), .reset_n(reset_n), .init(init), .go(go), .ret(ret),
        .grant(grant), .deny(deny), .credits(credits), .empty(empty), .full(full),
        .overflow_err(overflow_err), .state_o(state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] observed();
        return {state_o, overflow_err, full, empty, deny, grant, credits};
    endfunction

    function automatic logic [VW-1:0] expected();
        logic [1:0]    st;
        logic [CW-1:0] c;
        st = m_mode[1:0];
        c  = m_cred[CW-1:0];
        return {st, m_ovf[0], (m_cred == MAX), (m_cred == 0), m_deny[0], m_grant[0], c};
    endfunction

    function automatic void model_step(input logic rn, input logic i, input logic g, input logic r);
        m_grant = 0;
        m_deny  = 0;
        if (!rn) begin
            m_mode = 0; m_cred = 0; m_ovf = 0;
        end else if (i && m_mode != 0) begin
            m_cred = MAX; m_ovf = 0; m_mode = 1;
        end else if (m_mode == 0) begin
            if (i) begin m_cred = MAX; m_mode = 1; end
        end else if (m_mode == 2) begin
            m_deny = g ? 1 : 0;
        end else if (g) begin
            // a same-cycle return always pays for the request
            if (r || m_cred > 0) begin
                m_grant = 1;
                if (!r) m_cred = m_cred - 1;
            end else begin
                m_deny = 1;
            end
        end else if (r) begin
            if (m_cred < MAX) m_cred = m_cred + 1;
            else begin m_ovf = 1; m_mode = 2; end
        end
    endfunction

    task automatic tick(input logic rn, input logic i, input logic g, input logic r);
        reset_n = rn; init = i; go = g; ret = r;
        @(posedge clk);
        model_step(rn, i, g, r);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (observed() !== {2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, {CW{1'b0}}}) begin
            bad++; $display("FAIL reset_state: got %h exp %h", observed(), expected());
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 1'b0, k[0], ~k[0]);
            total++;
            if (observed() !== expected()) begin
                bad++; $display("FAIL idle_ignore[%0d]: got %h exp %h", k, observed(), expected());
            end
        end
    endtask

    task automatic test_init();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        total++;
        if (credits !== CW'(MAX) || full !== 1'b1 || state_o !== 2'd1) begin
            bad++; $display("FAIL init_load: got cred=%0d full=%b st=%0d exp cred=%0d full=1 st=1",
                            credits, full, state_o, MAX);
        end
    endtask

    task automatic test_drain();
        for (int k = 1; k <= 4; k++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0);
            total++;
            if (observed() !== expected()) begin
                bad++; $display("FAIL drain[%0d]: got %h exp %h", k, observed(), expected());
            end
        end
        total++;
        if (deny !== 1'b1 || grant !== 1'b0 || empty !== 1'b1 || credits !== '0) begin
            bad++; $display("FAIL drain_end: got deny=%b grant=%b empty=%b cred=%0d exp 1 0 1 0",
                            deny, grant, empty, credits);
        end
    endtask

    task automatic test_go_ret_empty();
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b1);
            total++;
            if (grant !== 1'b1 || deny !== 1'b0 || credits !== '0) begin
                bad++; $display("FAIL go_ret_empty[%0d]: got grant=%b deny=%b cred=%0d exp 1 0 0",
                                k, grant, deny, credits);
            end
        end
    endtask

    task automatic test_overflow();
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b1);
        total++;
        if (grant !== 1'b1 || overflow_err !== 1'b0 || credits !== CW'(MAX)) begin
            bad++; $display("FAIL go_ret_full: got grant=%b ovf=%b cred=%0d exp 1 0 %0d",
                            grant, overflow_err, credits, MAX);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (overflow_err !== 1'b1 || state_o !== 2'd2 || credits !== CW'(MAX)) begin
            bad++; $display("FAIL overflow: got ovf=%b st=%0d cred=%0d exp 1 2 %0d",
                            overflow_err, state_o, credits, MAX);
        end
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (deny !== 1'b1 || grant !== 1'b0 || overflow_err !== 1'b1) begin
            bad++; $display("FAIL err_deny: got deny=%b grant=%b ovf=%b exp 1 0 1", deny, grant, overflow_err);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        total++;
        if (observed() !== expected()) begin
            bad++; $display("FAIL err_ret_ignored: got %h exp %h", observed(), expected());
        end
        tick(1'b1, 1'b1, 1'b1, 1'b0);
        total++;
        if (credits !== CW'(MAX) || overflow_err !== 1'b0 || state_o !== 2'd1 || deny !== 1'b0) begin
            bad++; $display("FAIL err_init: got cred=%0d ovf=%b st=%0d deny=%b exp %0d 0 1 0",
                            credits, overflow_err, state_o, deny, MAX);
        end
    endtask

    task automatic test_reset_midrun();
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (credits !== CW'(MAX - 2)) begin
            bad++; $display("FAIL midrun_cred: got %0d exp %0d", credits, MAX - 2);
        end
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        total++;
        if (credits !== '0 || state_o !== 2'd0 || grant !== 1'b0 || deny !== 1'b0) begin
            bad++; $display("FAIL midrun_reset: got cred=%0d st=%0d g=%b d=%b exp 0 0 0 0",
                            credits, state_o, grant, deny);
        end
        for (int k = 0; k < 2; k++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0);
            total++;
            if (observed() !== expected() || grant !== 1'b0) begin
                bad++; $display("FAIL post_reset_go[%0d]: got %h exp %h", k, observed(), expected());
            end
        end
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        total++;
        if (observed() !== expected()) begin
            bad++; $display("FAIL reinit_go: got %h exp %h", observed(), expected());
        end
    endtask

    task automatic test_random();
        int granted;
        int returned;
        logic i, g, r, rn;
        granted  = 0;
        returned = 0;
        for (int k = 0; k < 1000; k++) begin
            rn = ($urandom_range(0, 199) != 0);
            i  = (k % 61 == 0) || ($urandom_range(0, 39) == 0);
            g  = $urandom_range(0, 1) == 1;
            r  = $urandom_range(0, 2) == 0;
            tick(rn, i, g, r);
            total++;
            if (observed() !== expected()) begin
                bad++; $display("FAIL random[%0d]: got %h exp %h (rn=%b i=%b g=%b r=%b)",
                                k, observed(), expected(), rn, i, g, r);
            end
            if (!rn || i) begin
                granted = 0; returned = 0;
            end else begin
                granted  += grant ? 1 : 0;
                returned += (m_mode == 1 && r && !g) ? 1 : 0;
            end
            total++;
            if ((grant && deny) || (credits > CW'(MAX))) begin
                bad++; $display("FAIL random_invariant[%0d]: got grant=%b deny=%b cred=%0d", k, grant, deny, credits);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; init = 1'b0; go = 1'b0; ret = 1'b0;
        m_mode = 0; m_cred = 0; m_grant = 0; m_deny = 0; m_ovf = 0;
        test_reset();
        test_init();
        test_drain();
        test_go_ret_empty();
        test_overflow();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/credit_down_counter.md
Name: credit_down_counter

Overview:
Credit tracker that pairs with an up-counting request source: it gates a `go` request stream so that no more than MAX_CREDITS requests are outstanding at once. Each granted request consumes one credit; each `ret` pulse returns one. It sits between a request generator and a downstream consumer, and enforces the bound in hardware rather than only checking it.

Parameters:
MAX_CREDITS, 3, credit pool size loaded by init; legal range 1..255
CW, $clog2(MAX_CREDITS+1), width of credit count; derived, do not override

Ports:
clk  input  1  clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset
init  input  1  load pool to MAX_CREDITS, clear errors
go  input  1  request one credit (level, sampled each cycle)
ret  input  1  return one credit (one credit per cycle asserted)
grant  output  1  registered one-cycle pulse, request accepted
deny  output  1  registered one-cycle pulse, request refused (no credit)
credits  output  CW  current available credits
empty  output  1  credits == 0 (combinational from credit register)
full  output  1  credits == MAX_CREDITS (combinational from credit register)
overflow_err  output  1  sticky, ret received while full
state_o  output  2  FSM state: 0=IDLE, 1=RUN, 2=ERR

Behaviour:
- Reset (reset_n=0 at clk edge): credits=0, grant=0, deny=0, overflow_err=0, state=IDLE. empty=1, full=0.
- Reset has priority over init, go and ret.
- Reset mid-operation discards all outstanding credits.
- IDLE:
  - go and ret are ignored; grant=deny=0.
  - init=1 -> credits=MAX_CREDITS, state=RUN next cycle.
- RUN, evaluated per cycle with registered results visible the next cycle:
  - init=1: credits=MAX_CREDITS, no grant/deny; init has priority over go/ret.
  - go=1, ret=0, credits>0: credits-1, grant=1.
  - go=1, ret=0, credits==0: credits unchanged, deny=1.
  - go=0, ret=1, credits<MAX: credits+1.
  - go=0, ret=1, credits==MAX: credits unchanged, overflow_err=1, state=ERR.
  - go=1, ret=1: net zero, credits unchanged, grant=1. This holds even when credits==0 and when credits==MAX, so no overflow is flagged.
  - go=0, ret=0: hold.
- ERR:
  - credits frozen; go produces deny=1; ret ignored.
  - overflow_err stays 1.
  - init=1 -> credits=MAX_CREDITS, overflow_err=0, state=RUN.
- Latency: request to grant/deny is exactly 1 cycle. Back-to-back go is accepted every cycle while credits last.
- Arithmetic:
  - credits never wraps: it never goes below 0 and never exceeds MAX_CREDITS.
  - All arithmetic is done at CW bits.
- Invariant: grant and deny are never both 1.
- Invariant: granted minus returned since the last init never exceeds MAX_CREDITS.

Optional Feature:
- Macro: CREDIT_SVA_EN.
- When defined, the block embeds concurrent assertions clocked on posedge clk with disable iff (!reset_n):
  - credits <= MAX_CREDITS.
  - not (grant && deny).
  - go && !ret && credits==0 in RUN |=> deny.
  - $rose(overflow_err) |-> $past(ret && full).
- Each assertion's failure message prints $time, credits and $sampled(credits).
- When not defined: no assertions, identical RTL behaviour.

Test Plan:
- Reset then init, MAX_CREDITS=3 -> credits=3, full=1, state=RUN one cycle after init.
- go held 4 cycles, no ret -> grant on cycles 1-3, credits 2,1,0, deny on cycle 4, empty=1.
- From credits=0, go=1 and ret=1 together for 2 cycles -> grant=1 both cycles, credits stays 0.
- From credits=3, ret=1 -> overflow_err=1, state=ERR; a following go gives deny=1; init -> credits=3, overflow_err=0, state=RUN.
- Mid-run (credits=1), reset_n=0 for one edge -> credits=0, state=IDLE, grant=deny=0; subsequent go is ignored until init.
- With CREDIT_SVA_EN, random go/ret for 1000 cycles with periodic init -> no assertion fires; forcing credits beyond 3 via a bench override fires the bound assertion.
